// File: rtl/instr_prefetch_queue.sv
// Instruction-fetch front end: issues imem reads from a fetch PC, queues returned words with PC+1.
// Optional macro PREFETCH_BYPASS_EN forwards a returning word straight to decode when the FIFO is empty.
module instr_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic [31:0]            address_imem,
    input  logic [31:0]            q_imem,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    input  logic                   instr_ready,
    output logic                   instr_valid,
    output logic [31:0]            instr_out,
    output logic [31:0]            pc_out,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int AW = $clog2(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("instr_prefetch_queue: DEPTH must be a power of two >= 2");
        end
    endgenerate

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    // State of the single imem read slot; DISCARD drops the returning word.
    typedef enum logic [1:0] {
        S_IDLE,
        S_PENDING,
        S_DISCARD
    } slot_t;

    slot_t           state, state_nxt;
    logic [31:0]     fetch_pc;
    logic [31:0]     issued_addr;
    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic [AW+1:0]   credit;
    entry_t          head, incoming;
    logic            inflight, capture, bypass_active;
    logic            deq, pop, push, issue;

    assign address_imem = fetch_pc;
    assign occupancy    = count;
    assign inflight     = (state != S_IDLE);
    assign capture      = (state == S_PENDING);
    assign head         = mem[rd_ptr];
    assign incoming     = '{instr: q_imem, pc: issued_addr + 32'd1};

`ifdef PREFETCH_BYPASS_EN
    assign bypass_active = capture && (count == '0);
`else
    assign bypass_active = 1'b0;
`endif

    assign deq  = instr_valid && instr_ready;
    assign pop  = deq && (count != '0);
    // A bypassed word taken by decode this cycle never enters the FIFO.
    assign push = capture && !redirect && !(bypass_active && instr_ready);

    // Credit counts queued words plus the outstanding read, minus this cycle's pop.
    assign credit = {1'b0, count}
                  + {{(AW+1){1'b0}}, inflight}
                  - {{(AW+1){1'b0}}, deq};
    assign issue  = !redirect && (credit < (AW+2)'(DEPTH));

    always_comb begin
        state_nxt = state;
        if (redirect)
            state_nxt = inflight ? S_DISCARD : S_IDLE;
        else if (issue)
            state_nxt = S_PENDING;
        else
            state_nxt = S_IDLE;
    end

    always_comb begin
        instr_valid = 1'b0;
        instr_out   = 32'd0;
        pc_out      = 32'd0;
        if (count != '0) begin
            instr_valid = 1'b1;
            instr_out   = head.instr;
            pc_out      = head.pc;
        end else if (bypass_active) begin
            instr_valid = 1'b1;
            instr_out   = incoming.instr;
            pc_out      = incoming.pc;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            fetch_pc    <= RESET_PC;
            issued_addr <= 32'd0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            state <= state_nxt;
            if (redirect) begin
                fetch_pc <= redirect_pc;
            end else if (issue) begin
                fetch_pc    <= fetch_pc + 32'd1;
                issued_addr <= fetch_pc;
            end
            if (redirect) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            end
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= incoming;
    end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue; imem model returns 0x1000 + address one cycle later.
module tb_instr_prefetch_queue;
    localparam int DEPTH = 4;
`ifdef PREFETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address_imem;
    logic [31:0] q_imem = 32'd0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        instr_ready = 1'b0;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [2:0]  occupancy;

    int n_chk  = 0;
    int n_pass = 0;

    instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'd0)) dut (
        .clock(clock), .reset(reset), .address_imem(address_imem), .q_imem(q_imem),
        .redirect(redirect), .redirect_pc(redirect_pc), .instr_ready(instr_ready),
        .instr_valid(instr_valid), .instr_out(instr_out), .pc_out(pc_out),
        .occupancy(occupancy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) q_imem <= 32'h1000 + address_imem;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    // Leaves the bench in the second half of cycle 0 with reset released.
    task automatic start(input logic rdy);
        reset = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; instr_ready = rdy;
        cyc(); cyc();
        reset = 1'b1;
    endtask

    initial begin
        // reset state
        cyc(); cyc();
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr_out, 32'd0);
        chk("rst_pc", pc_out, 32'd0);
        chk("rst_occ", {29'd0, occupancy}, 32'd0);
        chk("rst_addr", address_imem, 32'd0);

        // 1: streaming from reset
        start(1'b1);
        for (int c = 1; c <= 8; c++) begin
            cyc();
            chk("t1_valid", {31'd0, instr_valid}, (c >= LAT) ? 32'd1 : 32'd0);
            if (c >= LAT) begin
                chk("t1_instr", instr_out, 32'h1000 + c - LAT);
                chk("t1_pc", pc_out, c - LAT + 1);
            end
        end

        // 2: stall saturates FIFO, then drain with no gaps
        start(1'b0);
        for (int c = 1; c <= 10; c++) begin
            cyc();
            if (c >= 5) chk("t2_addr_hold", address_imem, 32'd4);
        end
        chk("t2_occ_full", {29'd0, occupancy}, 32'd4);
        chk("t2_head", instr_out, 32'h1000);
        instr_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk("t2_valid", {31'd0, instr_valid}, 32'd1);
            chk("t2_instr", instr_out, 32'h1000 + k);
            chk("t2_pc", pc_out, k + 1);
        end

        // 3: redirect with occupancy 3 and a read in flight
        start(1'b0);
        for (int c = 1; c <= 4; c++) cyc();
        chk("t3_occ3", {29'd0, occupancy}, 32'd3);
        redirect = 1'b1; redirect_pc = 32'h40; instr_ready = 1'b1;
        cyc();
        redirect = 1'b0;
        chk("t3_occ0", {29'd0, occupancy}, 32'd0);
        chk("t3_valid_r1", {31'd0, instr_valid}, 32'd0);
        chk("t3_addr", address_imem, 32'h40);
        for (int k = 2; k <= 5; k++) begin
            cyc();
            chk("t3_valid", {31'd0, instr_valid}, (k >= LAT + 1) ? 32'd1 : 32'd0);
            if (k >= LAT + 1) begin
                chk("t3_instr", instr_out, 32'h1040 + k - LAT - 1);
                chk("t3_pc", pc_out, 32'h41 + k - LAT - 1);
            end
        end

        // 4: back-to-back redirects, last one wins
        start(1'b1);
        for (int c = 1; c <= 5; c++) cyc();
        redirect = 1'b1; redirect_pc = 32'h40;
        cyc();
        redirect_pc = 32'h80;
        cyc();
        redirect = 1'b0;
        chk("t4_valid_r1", {31'd0, instr_valid}, 32'd0);
        chk("t4_addr", address_imem, 32'h80);
        for (int k = 2; k <= 5; k++) begin
            cyc();
            chk("t4_valid", {31'd0, instr_valid}, (k >= LAT + 1) ? 32'd1 : 32'd0);
            if (k >= LAT + 1) begin
                chk("t4_instr", instr_out, 32'h1080 + k - LAT - 1);
                chk("t4_pc", pc_out, 32'h81 + k - LAT - 1);
            end
        end

        // 5: asynchronous reset mid-stream
        start(1'b0);
        for (int c = 1; c <= 3; c++) cyc();
        chk("t5_occ2", {29'd0, occupancy}, 32'd2);
        #2 reset = 1'b0;
        #1;
        chk("t5_valid", {31'd0, instr_valid}, 32'd0);
        chk("t5_instr", instr_out, 32'd0);
        chk("t5_pc", pc_out, 32'd0);
        chk("t5_occ", {29'd0, occupancy}, 32'd0);
        chk("t5_addr", address_imem, 32'd0);
        instr_ready = 1'b1;
        cyc();
        reset = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            cyc();
            chk("t5_re_valid", {31'd0, instr_valid}, (c >= LAT) ? 32'd1 : 32'd0);
            if (c >= LAT) chk("t5_re_instr", instr_out, 32'h1000 + c - LAT);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
Instruction-fetch front end between the synchronous instruction memory and the decode stage. Generates `address_imem` from an internal fetch PC and captures the returned words into a small FIFO, each paired with its incremented PC. Presents instructions to decode through a valid/ready handshake, where ready is the inverse of the decode stall. Flushes on a redirect (taken branch or jump) and discards the imem read in flight at that moment.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
RESET_PC, 32'd0, first fetch address after reset (word address).

Ports:
clock  input  1  master clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset.
address_imem  output  32  fetch address to imem; equals the fetch PC.
q_imem  input  32  imem read data; valid in the cycle after its address was presented.
redirect  input  1  flush and refetch; asserted by execute on a taken branch or jump.
redirect_pc  input  32  new fetch address; sampled when redirect=1.
instr_ready  input  1  decode accepts the head entry this cycle (i.e. not stalled).
instr_valid  output  1  head entry is valid.
instr_out  output  32  head instruction word.
pc_out  output  32  incremented PC of the head instruction (its address + 1).
occupancy  output  log2(DEPTH)+1  current FIFO entry count.

Behaviour:
- Reset (asynchronous, reset=0):
  - fetch_pc=RESET_PC; FIFO empty; in-flight flag=0; discard flag=0.
  - instr_valid=0, instr_out=0, pc_out=0, occupancy=0.
  - address_imem=RESET_PC while held in reset.
- Addressing: word addressed; fetch_pc increments by 1 on each issue; 32-bit wrap from 0xFFFFFFFF to 0 with no flag.
- Issue rule, evaluated each cycle:
  - Issue iff redirect=0 and occupancy + inflight − deq < DEPTH, where deq = instr_valid & instr_ready.
  - On issue: set inflight=1, record the issued address, fetch_pc <= fetch_pc+1.
  - With no issue: fetch_pc holds, and address_imem still shows it (a harmless re-read).
- Capture: in the cycle after an issue, if discard=0, push {q_imem, issued_addr+1} at the tail.
- Overflow: the credit check guarantees the FIFO never overflows, so pushing into a full FIFO is unreachable. Simultaneous push and pop is legal at any occupancy.
- Dequeue: when instr_valid & instr_ready, pop the head.
  - instr_out and pc_out come combinationally from the head register.
  - While empty, instr_out and pc_out read 0 (NOP).
- Redirect (cycle r):
  - At the edge ending cycle r: FIFO cleared (occupancy=0), fetch_pc <= redirect_pc, no issue in cycle r.
  - If a read was in flight, set discard=1 so the word returning in cycle r+1 is dropped.
  - A dequeue handshake in cycle r completes as seen by decode; squashing it is execute's responsibility.
  - Redirect has priority over push, pop and issue.
- Latency: address presented in cycle n gives data in cycle n+1, a push at the end of n+1, and instr_valid in cycle n+2.
  - After a redirect in cycle r, the first valid instruction appears in cycle r+3.
- Throughput: with instr_ready held at 1, one instruction per cycle sustained in steady state, for any DEPTH ≥ 2.
- Back-to-back redirects: the last one wins. Each sets discard for its own in-flight read; no stale word is ever enqueued.
- State machine on the in-flight slot: IDLE → PENDING on issue; PENDING → PENDING on issue+capture; PENDING → IDLE on capture without issue. The DISCARD variant of PENDING is entered on redirect.

Optional Feature:
Macro: PREFETCH_BYPASS_EN.
- Defined: when the FIFO is empty and the returning word is not discarded, q_imem and its PC drive instr_out/pc_out combinationally with instr_valid=1 in the capture cycle.
  - If instr_ready=1 that cycle, the word is consumed and not pushed.
  - Redirect-to-first-valid drops to r+2; stream latency drops to n+1.
- Undefined: no bypass; all words pass through the FIFO, with latencies as above.

Test Plan:
1. Reset release, RESET_PC=0, imem[k]=0x1000+k, instr_ready=1 → instr_valid first in cycle 2; instr_out 0x1000, 0x1001, … one per cycle; pc_out 1, 2, 3, ….
2. instr_ready=0 for 10 cycles after reset → occupancy saturates at 4 and address_imem stops at 4. On release, the words for addresses 0–3 drain in order with no gaps, then streaming continues.
3. redirect=1, redirect_pc=0x40 while a read is in flight and occupancy=3 → occupancy 0 the next cycle; the in-flight word is never output; the next instr_out is imem[0x40] with pc_out 0x41, valid exactly 3 cycles after redirect.
4. Redirect in two consecutive cycles (0x40, then 0x80) → only imem[0x80…] appears; no word from address 0x40 is ever valid.
5. Assert reset mid-stream with occupancy=2 → outputs go to 0 immediately without waiting for a clock; refetch restarts from RESET_PC after release.
6. PREFETCH_BYPASS_EN defined, repeat scenarios 1 and 3 → first valid appears in cycle 1, and in scenario 3 two cycles after the redirect; instruction order and values are unchanged.
